entropy_src_arbiter: RTL and testbench

// - Sequences and shares the TRNG entropy sources (avalanche, rosc, cpu-jitter) towards the mixer.
// - Round-robin over enabled sources; takes one 32-bit word per grant, acks that source, presents the word downstream.
// - A per-grant timeout skips stalled sources; skip events are counted for health monitoring.
// - Sits between the rosc_entropy-style source modules and trng_mixer.

---
 rtl/entropy_src_arbiter_pkg.sv | 32 +++
 rtl/entropy_src_arbiter_if.sv | 29 ++
 rtl/entropy_src_arbiter_rr_select.sv | 30 +++
 rtl/entropy_src_arbiter.sv | 137 +++++++++++++
 tb/tb_entropy_src_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/entropy_src_arbiter_pkg.sv
// Shared types and helpers for the entropy source arbiter: FSM states,
// source ids, word width and the round-robin distance function.
package entropy_src_arbiter_pkg;

    localparam int WORD_W = 32;
    localparam int ID_W   = 2;

    localparam logic [7:0] TIMEOUT_CNT_MAX = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_WAIT   = 2'd2,
        ST_OUTPUT = 2'd3
    } arb_state_e;

    typedef enum logic [ID_W-1:0] {
        SRC_AVALANCHE = 2'd0,
        SRC_ROSC      = 2'd1,
        SRC_CPU       = 2'd2
    } src_id_e;

    // Steps from ptr forward to cand; ptr itself is the farthest (n steps).
    function automatic int rr_dist(input int cand, input int ptr, input int n);
        return (cand > ptr) ? (cand - ptr) : (cand - ptr + n);
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == TIMEOUT_CNT_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/entropy_src_arbiter_if.sv
// Source-side and mixer-side signals of the entropy arbiter, bundled.
// master = arbiter, slave = the sources/mixer environment.
interface entropy_src_arbiter_if
    import entropy_src_arbiter_pkg::*;
#(
    parameter int NUM_SRC = 3
);
    logic                      collect_en;
    logic [NUM_SRC-1:0]        src_enabled;
    logic [NUM_SRC-1:0]        src_valid;
    logic [WORD_W*NUM_SRC-1:0] src_data;
    logic [NUM_SRC-1:0]        src_ack;
    logic [WORD_W-1:0]         out_data;
    logic [ID_W-1:0]           out_src;
    logic                      out_valid;
    logic                      out_ack;
    logic                      no_source;
    logic [7:0]                timeout_count;

    modport master (
        input  collect_en, src_enabled, src_valid, src_data, out_ack,
        output src_ack, out_data, out_src, out_valid, no_source, timeout_count
    );

    modport slave (
        output collect_en, src_enabled, src_valid, src_data, out_ack,
        input  src_ack, out_data, out_src, out_valid, no_source, timeout_count
    );
endinterface

// File: rtl/entropy_src_arbiter_rr_select.sv
// Combinational round-robin finder: first enabled source after ptr,
// wrapping around, with ptr itself as the last candidate.
module entropy_rr_select
    import entropy_src_arbiter_pkg::*;
#(
    parameter int NUM_SRC = 3
) (
    input  logic [ID_W-1:0]    ptr,
    input  logic [NUM_SRC-1:0] src_enabled,
    output logic               found,
    output logic [ID_W-1:0]    next_id
);

    int best;

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        found   = 1'b0;
        next_id = ptr;
        best    = NUM_SRC + 1;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_enabled[i] && (rr_dist(i, int'(ptr), NUM_SRC) < best)) begin
                found   = 1'b1;
                next_id = ID_W'(i);
                best    = rr_dist(i, int'(ptr), NUM_SRC);
            end
        end
    end

endmodule

// File: rtl/entropy_src_arbiter.sv
// Round-robin arbiter taking one word per grant from the TRNG sources,
// skipping stalled sources after a timeout and holding each word for the mixer.
module entropy_src_arbiter
    import entropy_src_arbiter_pkg::*;
#(
    parameter int          NUM_SRC = 3,
    parameter logic [15:0] TIMEOUT = 16'h0100
) (
    input logic                  clk,
    input logic                  reset_n,
    entropy_src_arbiter_if.master bus
);

    arb_state_e         state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [15:0]        timer_q, timer_d;
    logic [NUM_SRC-1:0] src_ack_q, src_ack_d;
    logic [WORD_W-1:0]  out_data_q, out_data_d;
    logic [ID_W-1:0]    out_src_q, out_src_d;
    logic               out_valid_q, out_valid_d;
    logic               no_source_q, no_source_d;
    logic [7:0]         tmo_cnt_q, tmo_cnt_d;

    logic               sel_found;
    logic [ID_W-1:0]    sel_id;
    logic [WORD_W-1:0]  cur_word;
    logic               cur_valid;
    logic               cur_enabled;

    entropy_rr_select #(.NUM_SRC(NUM_SRC)) u_rr_select (
        .ptr        (ptr_q),
        .src_enabled(bus.src_enabled),
        .found      (sel_found),
        .next_id    (sel_id)
    );

    always_comb begin
        cur_word    = '0;
        cur_valid   = 1'b0;
        cur_enabled = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (ptr_q == ID_W'(i)) begin
                cur_word    = bus.src_data[i*WORD_W +: WORD_W];
                cur_valid   = bus.src_valid[i];
                cur_enabled = bus.src_enabled[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        timer_d     = timer_q;
        src_ack_d   = '0;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_valid_d = out_valid_q;
        no_source_d = no_source_q;
        tmo_cnt_d   = tmo_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.collect_en) state_d = ST_SELECT;
            end
            ST_SELECT: begin
                if (sel_found) begin
                    ptr_d       = sel_id;
                    timer_d     = '0;
                    no_source_d = 1'b0;
                    state_d     = ST_WAIT;
                end else begin
                    no_source_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!bus.collect_en) begin
                    state_d = ST_IDLE;
                end else if (!cur_enabled) begin
                    state_d = ST_SELECT;
                end else if (cur_valid) begin
                    out_data_d  = cur_word;
                    out_src_d   = ptr_q;
                    out_valid_d = 1'b1;
                    for (int i = 0; i < NUM_SRC; i++) src_ack_d[i] = (ptr_q == ID_W'(i));
                    state_d     = ST_OUTPUT;
                end else if (timer_q == TIMEOUT - 16'd1) begin
                    tmo_cnt_d = sat_inc8(tmo_cnt_q);
                    state_d   = ST_SELECT;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            ST_OUTPUT: begin
                // The word survives a collect_en drop; only out_ack releases it.
                if (bus.out_ack) begin
                    out_valid_d = 1'b0;
                    state_d     = bus.collect_en ? ST_SELECT : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= ID_W'(NUM_SRC - 1);
            timer_q     <= '0;
            src_ack_q   <= '0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_valid_q <= 1'b0;
            no_source_q <= 1'b0;
            tmo_cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from pre-edge values.
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            timer_q     <= timer_d;
            src_ack_q   <= src_ack_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_valid_q <= out_valid_d;
            no_source_q <= no_source_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    assign bus.src_ack       = src_ack_q;
    assign bus.out_data      = out_data_q;
    assign bus.out_src       = out_src_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.no_source     = no_source_q;
    assign bus.timeout_count = tmo_cnt_q;

endmodule

// File: tb/tb_entropy_src_arbiter.sv
// Bench for entropy_src_arbiter: directed scenarios plus randomized episodes
// checked against a transaction-level round-robin model.
module tb_entropy_src_arbiter;
    import entropy_src_arbiter_pkg::*;

    localparam int          NUM_SRC = 3;
    localparam logic [15:0] TMO     = 16'd16;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    entropy_src_arbiter_if #(.NUM_SRC(NUM_SRC)) bus ();

    entropy_src_arbiter #(.NUM_SRC(NUM_SRC), .TIMEOUT(TMO)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus.master)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Source emulation: directed values, or self-timed sources in auto mode.
    logic               auto_mode = 1'b0;
    logic [NUM_SRC-1:0] alive     = '0;
    logic [NUM_SRC-1:0] dir_valid = '0;
    logic [31:0]        dir_data [NUM_SRC];
    logic [31:0]        cur_word [NUM_SRC];
    int                 lat      [NUM_SRC];

    initial begin
        bus.src_valid = '0;
        bus.src_data  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            cur_word[i] = $urandom;
            lat[i]      = 0;
        end
        forever begin
            @(negedge clk);
            #3;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (auto_mode) begin
                    if (bus.src_ack[i]) begin
                        cur_word[i] = $urandom;
                        lat[i]      = $urandom_range(0, 6);
                    end else if (lat[i] > 0) begin
                        lat[i]--;
                    end
                    bus.src_valid[i]         = alive[i] && (lat[i] == 0);
                    bus.src_data[i*32 +: 32] = cur_word[i];
                end else begin
                    bus.src_valid[i]         = dir_valid[i];
                    bus.src_data[i*32 +: 32] = dir_data[i];
                end
            end
        end
    end

    // Ack pulse bookkeeping: counts per source and any multi-hot or 2-cycle ack.
    int                 ack_cnt [NUM_SRC];
    int                 ack_bad = 0;
    logic [NUM_SRC-1:0] ack_prev = '0;

    initial begin
        for (int i = 0; i < NUM_SRC; i++) ack_cnt[i] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NUM_SRC; i++) if (bus.src_ack[i] === 1'b1) ack_cnt[i]++;
            if ($countones(bus.src_ack) > 1 || (bus.src_ack != 0 && ack_prev != 0)) ack_bad++;
            ack_prev = bus.src_ack;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_word(input string tag, input int exp_src, input logic [31:0] exp_data,
                             input int budget, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (bus.out_valid !== 1'b1 && cyc < budget);
        check({tag, " out_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, " out_src"},   32'(bus.out_src),   32'(exp_src));
        check({tag, " out_data"},  bus.out_data,       exp_data);
        check({tag, " src_ack"},   32'(bus.src_ack),   32'(1) << exp_src);
    endtask

    task automatic do_reset();
        bus.collect_en = 1'b0;
        bus.out_ack    = 1'b0;
        reset_n        = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    function automatic int ack_sum();
        int s = 0;
        for (int i = 0; i < NUM_SRC; i++) s += ack_cnt[i];
        return s;
    endfunction

    initial begin
        int          cyc;
        int          base [NUM_SRC];
        int          snap;
        int          bad;
        int          hold;
        int          last;
        int          skips;
        logic [31:0] held;

        bus.collect_en  = 1'b0;
        bus.src_enabled = '0;
        bus.out_ack     = 1'b0;
        dir_data[0] = 32'haa55aa55;
        dir_data[1] = 32'h11111111;
        dir_data[2] = 32'h22222222;

        // Reset values
        tick();
        tick();
        check("rst src_ack",       32'(bus.src_ack),       32'd0);
        check("rst out_data",      bus.out_data,           32'd0);
        check("rst out_src",       32'(bus.out_src),       32'd0);
        check("rst out_valid",     32'(bus.out_valid),     32'd0);
        check("rst no_source",     32'(bus.no_source),     32'd0);
        check("rst timeout_count", 32'(bus.timeout_count), 32'd0);
        reset_n = 1'b1;
        tick();

        // All enabled, all valid, out_ack tied high: 0,1,2,0 every 3 cycles
        bus.src_enabled = '1;
        dir_valid       = '1;
        bus.out_ack     = 1'b1;
        tick();
        for (int i = 0; i < NUM_SRC; i++) base[i] = ack_cnt[i];
        bus.collect_en = 1'b1;
        wait_word("t1 w0", 0, dir_data[0], 16, cyc);
        check("t1 latency", 32'(cyc), 32'd3);
        for (int k = 1; k < 4; k++) begin
            wait_word("t1 wn", k % 3, dir_data[k % 3], 16, cyc);
            check("t1 spacing", 32'(cyc), 32'd3);
        end
        check("t1 acks src0", 32'(ack_cnt[0] - base[0]), 32'd2);
        check("t1 acks src1", 32'(ack_cnt[1] - base[1]), 32'd1);
        check("t1 acks src2", 32'(ack_cnt[2] - base[2]), 32'd1);

        // Sources 0 and 2 only: alternate, source 1 never acked
        do_reset();
        bus.src_enabled = 3'b101;
        bus.out_ack     = 1'b1;
        snap            = ack_cnt[1];
        bus.collect_en  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_word("t2 alt", (k % 2) ? 2 : 0, (k % 2) ? dir_data[2] : dir_data[0], 16, cyc);
        end
        check("t2 src1 acks", 32'(ack_cnt[1] - snap), 32'd0);

        // Source 1 stalled: TIMEOUT cycles in WAIT, then skip; counter saturates
        do_reset();
        bus.src_enabled = '1;
        dir_valid       = 3'b101;
        bus.out_ack     = 1'b1;
        tick();
        bus.collect_en = 1'b1;
        wait_word("t3 first", 0, dir_data[0], 16, cyc);
        wait_word("t3 skip", 2, dir_data[2], 64, cyc);
        check("t3 skip gap", 32'(cyc), 32'd3 + 32'(TMO) + 32'd1);
        check("t3 count1", 32'(bus.timeout_count), 32'd1);
        for (int k = 2; k <= 300; k++) begin
            wait_word("t3 loop0", 0, dir_data[0], 64, cyc);
            wait_word("t3 loop2", 2, dir_data[2], 64, cyc);
            check("t3 count", 32'(bus.timeout_count), 32'((k > 255) ? 255 : k));
        end

        // No source enabled, then source 2 appears
        do_reset();
        bus.src_enabled = '0;
        dir_valid       = '1;
        bus.out_ack     = 1'b1;
        bus.collect_en  = 1'b1;
        repeat (6) tick();
        check("t4 no_source set", 32'(bus.no_source), 32'd1);
        check("t4 no word",       32'(bus.out_valid), 32'd0);
        bus.src_enabled = 3'b100;
        wait_word("t4 src2", 2, dir_data[2], 32, cyc);
        check("t4 no_source clr", 32'(bus.no_source), 32'd0);

        // Back-pressure: word held 50 cycles, collect_en drop keeps the word
        do_reset();
        bus.src_enabled = '1;
        dir_valid       = '1;
        bus.collect_en  = 1'b1;
        wait_word("t5 word", 0, dir_data[0], 16, cyc);
        snap = ack_sum();
        bad  = 0;
        for (int c = 0; c < 50; c++) begin
            for (int i = 0; i < NUM_SRC; i++) dir_data[i] = $urandom;
            if (c == 25) bus.collect_en = 1'b0;
            tick();
            if (bus.out_valid !== 1'b1 || bus.out_data !== 32'haa55aa55) bad++;
        end
        check("t5 held cycles", 32'(bad), 32'd0);
        check("t5 held data", bus.out_data, 32'haa55aa55);
        check("t5 no new ack", 32'(ack_sum() - snap), 32'd0);
        bus.out_ack = 1'b1;
        tick();
        check("t5 accepted", 32'(bus.out_valid), 32'd0);
        bus.out_ack = 1'b0;
        repeat (5) tick();
        check("t5 idle no word", 32'(bus.out_valid), 32'd0);
        check("t5 idle no ack", 32'(ack_sum() - snap), 32'd0);
        dir_data[0] = 32'haa55aa55;
        dir_data[1] = 32'h11111111;
        dir_data[2] = 32'h22222222;

        // Reset during WAIT (after a timeout) and during OUTPUT
        do_reset();
        bus.src_enabled = '1;
        dir_valid       = '0;
        bus.collect_en  = 1'b1;
        repeat (22) tick();
        check("t6 pre count", 32'(bus.timeout_count), 32'd1);
        reset_n = 1'b0;
        #1;
        check("t6 wait rst count", 32'(bus.timeout_count), 32'd0);
        check("t6 wait rst valid", 32'(bus.out_valid), 32'd0);
        bus.collect_en = 1'b0;
        tick();
        reset_n         = 1'b1;
        bus.src_enabled = 3'b010;
        dir_valid       = '1;
        bus.out_ack     = 1'b0;
        tick();
        bus.collect_en = 1'b1;
        wait_word("t6 pre", 1, dir_data[1], 16, cyc);
        bus.src_enabled = '1;
        tick();
        check("t6 still held", 32'(bus.out_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        check("t6 out rst valid", 32'(bus.out_valid), 32'd0);
        check("t6 out rst data",  bus.out_data,       32'd0);
        check("t6 out rst src",   32'(bus.out_src),   32'd0);
        check("t6 out rst ack",   32'(bus.src_ack),   32'd0);
        tick();
        reset_n     = 1'b1;
        bus.out_ack = 1'b1;
        wait_word("t6 post", 0, dir_data[0], 16, cyc);

        // Randomized episodes against a round-robin transaction model
        do_reset();
        auto_mode = 1'b1;
        last      = NUM_SRC - 1;
        skips     = 0;
        for (int e = 0; e < 40; e++) begin
            logic [NUM_SRC-1:0] en;
            logic [NUM_SRC-1:0] al;
            int                 nw;
            do begin
                en = NUM_SRC'($urandom_range(1, 7));
                al = NUM_SRC'($urandom_range(0, 7));
            end while ((en & al) == 0);
            bus.src_enabled = en;
            alive           = al;
            nw              = $urandom_range(2, 6);
            tick();
            bus.collect_en = 1'b1;
            for (int w = 0; w < nw; w++) begin
                int exp_id;
                exp_id = last;
                do begin
                    exp_id = (exp_id + 1) % NUM_SRC;
                    if (en[exp_id] && !al[exp_id]) skips++;
                end while (!(en[exp_id] && al[exp_id]));
                last = exp_id;

                cyc = 0;
                do begin
                    bus.out_ack = 1'($urandom_range(0, 1));
                    tick();
                    cyc++;
                end while (bus.out_valid !== 1'b1 && cyc < 400);
                check("rnd out_valid", 32'(bus.out_valid),     32'd1);
                check("rnd out_src",   32'(bus.out_src),       32'(exp_id));
                check("rnd out_data",  bus.out_data,           cur_word[exp_id]);
                check("rnd src_ack",   32'(bus.src_ack),       32'(1) << exp_id);
                check("rnd tmo count", 32'(bus.timeout_count), 32'((skips > 255) ? 255 : skips));

                held = bus.out_data;
                bad  = 0;
                hold = 0;
                if (w == nw - 1) bus.collect_en = 1'b0;
                do begin
                    bus.out_ack = 1'($urandom_range(0, 1));
                    tick();
                    hold++;
                    if (bus.out_valid === 1'b1 && bus.out_data !== held) bad++;
                end while (bus.out_valid === 1'b1 && hold < 400);
                check("rnd held stable", 32'(bad), 32'd0);
                check("rnd accepted", 32'(bus.out_valid), 32'd0);
            end
            bus.out_ack = 1'b0;
            repeat (3) tick();
        end

        check("ack single pulse", 32'(ack_bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
